// File: rtl/branch_predict_resolve_if.sv
// Fetch-side prediction and EX-side resolution signals of the branch unit.
// The slave modport faces the branch unit; the master faces the pipeline.
interface branch_predict_resolve_if #(
    parameter int XLEN = 32
);
    logic [XLEN-1:0] if_pc;
    logic            pred_taken;
    logic [XLEN-1:0] pred_target;
    logic            ex_valid;
    logic            ex_stall;
    logic [XLEN-1:0] ex_pc;
    logic [6:0]      ex_opcode;
    logic [2:0]      ex_func3;
    logic [XLEN-1:0] ex_rs1;
    logic [XLEN-1:0] ex_rs2;
    logic [XLEN-1:0] ex_target;
    logic            ex_pred_taken;
    logic [XLEN-1:0] ex_pred_target;
    logic            bj_taken;
    logic            mispredict;
    logic [XLEN-1:0] redirect_pc;

    modport master (
        output if_pc, ex_valid, ex_stall, ex_pc, ex_opcode, ex_func3,
        output ex_rs1, ex_rs2, ex_target, ex_pred_taken, ex_pred_target,
        input  pred_taken, pred_target, bj_taken, mispredict, redirect_pc
    );

    modport slave (
        input  if_pc, ex_valid, ex_stall, ex_pc, ex_opcode, ex_func3,
        input  ex_rs1, ex_rs2, ex_target, ex_pred_taken, ex_pred_target,
        output pred_taken, pred_target, bj_taken, mispredict, redirect_pc
    );
endinterface

// File: rtl/branch_predict_resolve.sv
// BTB + 2-bit counter predictor with EX-stage branch/jump resolution.
// Define BRANCH_PERF_EN to build the resolved/mispredict perf counters.
module branch_predict_resolve #(
    parameter int XLEN      = 32,
    parameter int BTB_DEPTH = 64,
    parameter int TAG_W     = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    branch_predict_resolve_if.slave bus,
    output logic [31:0] perf_br_cnt,
    output logic [31:0] perf_mispred_cnt
);
    localparam int IDX_W = $clog2(BTB_DEPTH);

    localparam logic [6:0] OP_BR   = 7'b1100011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;
    localparam logic [6:0] OP_JALR = 7'b1100111;

    logic             v_q   [BTB_DEPTH];
    logic [TAG_W-1:0] tag_q [BTB_DEPTH];
    logic [XLEN-1:0]  tgt_q [BTB_DEPTH];
    logic             jmp_q [BTB_DEPTH];
    logic [1:0]       cnt_q [BTB_DEPTH];

    logic [IDX_W-1:0] if_idx;
    logic [TAG_W-1:0] if_tag;
    logic             if_hit;
    logic [IDX_W-1:0] ex_idx;
    logic [TAG_W-1:0] ex_tag;
    logic             ex_hit;

    logic       is_br;
    logic       is_jmp;
    logic       ctrl;
    logic       cond;
    logic       upd;
    logic [1:0] cnt_nxt;

    assign if_idx = bus.if_pc[IDX_W+1:2];
    assign if_tag = bus.if_pc[IDX_W+TAG_W+1:IDX_W+2];
    assign if_hit = v_q[if_idx] && (tag_q[if_idx] == if_tag);

    assign bus.pred_taken  = if_hit & (jmp_q[if_idx] | cnt_q[if_idx][1]);
    assign bus.pred_target = bus.pred_taken ? tgt_q[if_idx]
                                            : bus.if_pc + XLEN'(4);

    assign is_br  = (bus.ex_opcode == OP_BR);
    assign is_jmp = (bus.ex_opcode == OP_JAL) || (bus.ex_opcode == OP_JALR);
    assign ctrl   = is_br | is_jmp;

    always_comb begin
        cond = 1'b0;
        unique case (bus.ex_func3)
            3'b000:  cond = (bus.ex_rs1 == bus.ex_rs2);
            3'b001:  cond = (bus.ex_rs1 != bus.ex_rs2);
            3'b100:  cond = ($signed(bus.ex_rs1) <  $signed(bus.ex_rs2));
            3'b101:  cond = ($signed(bus.ex_rs1) >= $signed(bus.ex_rs2));
            3'b110:  cond = (bus.ex_rs1 <  bus.ex_rs2);
            3'b111:  cond = (bus.ex_rs1 >= bus.ex_rs2);
            default: cond = 1'b0;
        endcase
    end

    assign bus.bj_taken    = is_jmp | (is_br & cond);
    assign bus.redirect_pc = bus.bj_taken ? bus.ex_target
                                          : bus.ex_pc + XLEN'(4);
    assign bus.mispredict  = bus.ex_valid & ctrl &
        ((bus.ex_pred_taken != bus.bj_taken) |
         (bus.bj_taken & (bus.ex_pred_target != bus.ex_target)));

    assign upd    = bus.ex_valid & ~bus.ex_stall & ctrl;
    assign ex_idx = bus.ex_pc[IDX_W+1:2];
    assign ex_tag = bus.ex_pc[IDX_W+TAG_W+1:IDX_W+2];
    assign ex_hit = v_q[ex_idx] && (tag_q[ex_idx] == ex_tag);

    always_comb begin
        cnt_nxt = cnt_q[ex_idx];
        if (bus.bj_taken) begin
            if (cnt_nxt != 2'b11) cnt_nxt = cnt_nxt + 2'd1;
        end else if (cnt_nxt != 2'b00) begin
            cnt_nxt = cnt_nxt - 2'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < BTB_DEPTH; i++) begin
                v_q[i]   <= 1'b0;
                tag_q[i] <= '0;
                tgt_q[i] <= '0;
                jmp_q[i] <= 1'b0;
                cnt_q[i] <= 2'b01;
            end
        end else if (upd) begin
            if (ex_hit && is_jmp) begin
                tgt_q[ex_idx] <= bus.ex_target;
                jmp_q[ex_idx] <= 1'b1;
                cnt_q[ex_idx] <= 2'b11;
            end else if (ex_hit) begin
                cnt_q[ex_idx] <= cnt_nxt;
                if (bus.bj_taken) tgt_q[ex_idx] <= bus.ex_target;
            end else if (bus.bj_taken) begin
                // miss or alias: a taken outcome claims the slot
                v_q[ex_idx]   <= 1'b1;
                tag_q[ex_idx] <= ex_tag;
                tgt_q[ex_idx] <= bus.ex_target;
                jmp_q[ex_idx] <= is_jmp;
                cnt_q[ex_idx] <= is_jmp ? 2'b11 : 2'b10;
            end
        end
    end

`ifdef BRANCH_PERF_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_br_cnt      <= '0;
            perf_mispred_cnt <= '0;
        end else if (upd) begin
            perf_br_cnt <= perf_br_cnt + 32'd1;
            if (bus.mispredict) perf_mispred_cnt <= perf_mispred_cnt + 32'd1;
        end
    end
`else
    assign perf_br_cnt      = '0;
    assign perf_mispred_cnt = '0;
`endif

    logic unused_pc_bits;
    assign unused_pc_bits = ^{bus.if_pc, bus.ex_pc};
endmodule

// File: tb/tb_branch_predict_resolve.sv
// Directed bench for branch_predict_resolve with a table-level reference model.
// Compares every output on each falling edge, plus hand-computed spot checks.
module tb_branch_predict_resolve;
    localparam int DEPTH = 64;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] perf_br_cnt;
    logic [31:0] perf_mispred_cnt;

    int errors = 0;
    int checks = 0;

    branch_predict_resolve_if #(.XLEN(32)) bus ();

    branch_predict_resolve #(
        .XLEN(32), .BTB_DEPTH(DEPTH), .TAG_W(8)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .bus              (bus),
        .perf_br_cnt      (perf_br_cnt),
        .perf_mispred_cnt (perf_mispred_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          v;
        int unsigned tag;
        bit [31:0]   tgt;
        bit          jmp;
        int          cnt;
    } ent_t;

    ent_t      m [DEPTH];
    bit [31:0] m_br;
    bit [31:0] m_mis;

    function automatic int unsigned m_idx(bit [31:0] pc);
        return (pc / 4) % DEPTH;
    endfunction

    function automatic int unsigned m_tag(bit [31:0] pc);
        return (pc / (4 * DEPTH)) % 256;
    endfunction

    function automatic bit m_is_jump(bit [6:0] op);
        return op == 7'b1101111 || op == 7'b1100111;
    endfunction

    function automatic bit m_is_ctrl(bit [6:0] op);
        return m_is_jump(op) || op == 7'b1100011;
    endfunction

    function automatic bit m_taken(bit [6:0] op, bit [2:0] f3,
                                   bit [31:0] a, bit [31:0] b);
        int sa;
        int sb;
        sa = a;
        sb = b;
        if (m_is_jump(op)) return 1'b1;
        if (op != 7'b1100011) return 1'b0;
        case (f3)
            3'd0: return a == b;
            3'd1: return a != b;
            3'd4: return sa < sb;
            3'd5: return sa >= sb;
            3'd6: return a < b;
            3'd7: return a >= b;
            default: return 1'b0;
        endcase
    endfunction

    function automatic bit m_mispred();
        bit tk;
        tk = m_taken(bus.ex_opcode, bus.ex_func3, bus.ex_rs1, bus.ex_rs2);
        if (!(bus.ex_valid && m_is_ctrl(bus.ex_opcode))) return 1'b0;
        if (bus.ex_pred_taken != tk) return 1'b1;
        return tk && (bus.ex_pred_target != bus.ex_target);
    endfunction

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference table: trained from EX inputs at each rising edge.
    always @(posedge clk or negedge rst_n) begin
        int unsigned i;
        bit tk;
        bit hit;
        if (!rst_n) begin
            for (int k = 0; k < DEPTH; k++) begin
                m[k].v   <= 1'b0;
                m[k].tag <= 0;
                m[k].tgt <= '0;
                m[k].jmp <= 1'b0;
                m[k].cnt <= 1;
            end
            m_br  <= '0;
            m_mis <= '0;
        end else if (bus.ex_valid && !bus.ex_stall && m_is_ctrl(bus.ex_opcode)) begin
            i   = m_idx(bus.ex_pc);
            tk  = m_taken(bus.ex_opcode, bus.ex_func3, bus.ex_rs1, bus.ex_rs2);
            hit = m[i].v && m[i].tag == m_tag(bus.ex_pc);
            m_br <= m_br + 1;
            if (m_mispred()) m_mis <= m_mis + 1;
            if (hit && m_is_jump(bus.ex_opcode)) begin
                m[i].tgt <= bus.ex_target;
                m[i].jmp <= 1'b1;
                m[i].cnt <= 3;
            end else if (hit) begin
                m[i].cnt <= tk ? (m[i].cnt < 3 ? m[i].cnt + 1 : 3)
                               : (m[i].cnt > 0 ? m[i].cnt - 1 : 0);
                if (tk) m[i].tgt <= bus.ex_target;
            end else if (tk) begin
                m[i].v   <= 1'b1;
                m[i].tag <= m_tag(bus.ex_pc);
                m[i].tgt <= bus.ex_target;
                m[i].jmp <= m_is_jump(bus.ex_opcode);
                m[i].cnt <= m_is_jump(bus.ex_opcode) ? 3 : 2;
            end
        end
    end

    // Output comparison against the model every falling edge.
    always @(negedge clk) begin
        int unsigned i;
        bit pt;
        bit tk;
        bit [31:0] ptg;
        i   = m_idx(bus.if_pc);
        pt  = m[i].v && m[i].tag == m_tag(bus.if_pc) && (m[i].jmp || m[i].cnt >= 2);
        ptg = pt ? m[i].tgt : bus.if_pc + 32'd4;
        tk  = m_taken(bus.ex_opcode, bus.ex_func3, bus.ex_rs1, bus.ex_rs2);
        chk("m_pred_taken", {31'd0, bus.pred_taken}, {31'd0, pt});
        chk("m_pred_target", bus.pred_target, ptg);
        chk("m_bj_taken", {31'd0, bus.bj_taken}, {31'd0, tk});
        chk("m_mispredict", {31'd0, bus.mispredict}, {31'd0, m_mispred()});
        chk("m_redirect_pc", bus.redirect_pc, tk ? bus.ex_target : bus.ex_pc + 32'd4);
`ifdef BRANCH_PERF_EN
        chk("m_perf_br", perf_br_cnt, m_br);
        chk("m_perf_mis", perf_mispred_cnt, m_mis);
`else
        chk("m_perf_br", perf_br_cnt, 32'd0);
        chk("m_perf_mis", perf_mispred_cnt, 32'd0);
`endif
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ex(bit stall, bit [31:0] pc, bit [6:0] op, bit [2:0] f3,
                      bit [31:0] a, bit [31:0] b, bit [31:0] tgt,
                      bit pt, bit [31:0] ptg);
        bus.ex_valid       = 1'b1;
        bus.ex_stall       = stall;
        bus.ex_pc          = pc;
        bus.ex_opcode      = op;
        bus.ex_func3       = f3;
        bus.ex_rs1         = a;
        bus.ex_rs2         = b;
        bus.ex_target      = tgt;
        bus.ex_pred_taken  = pt;
        bus.ex_pred_target = ptg;
    endtask

    task automatic idle();
        bus.ex_valid  = 1'b0;
        bus.ex_stall  = 1'b0;
        bus.ex_opcode = 7'b0010011;
    endtask

    localparam bit [6:0] BR   = 7'b1100011;
    localparam bit [6:0] JAL  = 7'b1101111;
    localparam bit [6:0] JALR = 7'b1100111;

    initial begin
        bus.if_pc = 32'h100;
        ex(1'b0, 32'h0, 7'b0010011, 3'd0, 0, 0, 0, 1'b0, 0);
        idle();
        @(negedge clk);
        chk("rst_pred_taken", {31'd0, bus.pred_taken}, 32'd0);
        chk("rst_pred_target", bus.pred_target, 32'h104);
        #2 rst_n = 1'b1;
        tick();

        // BEQ allocates, IF sees the old contents in the same cycle
        bus.if_pc = 32'h200;
        ex(1'b0, 32'h200, BR, 3'd0, 5, 5, 32'h240, 1'b0, 32'h0);
        @(negedge clk);
        chk("beq_taken", {31'd0, bus.bj_taken}, 32'd1);
        chk("beq_mispred", {31'd0, bus.mispredict}, 32'd1);
        chk("beq_redirect", bus.redirect_pc, 32'h240);
        chk("beq_no_bypass", {31'd0, bus.pred_taken}, 32'd0);
        tick();
        @(negedge clk);
        chk("beq_pred_taken", {31'd0, bus.pred_taken}, 32'd1);
        chk("beq_pred_target", bus.pred_target, 32'h240);
        tick();

        ex(1'b0, 32'h400, BR, 3'd4, 32'hFFFF_FFFF, 1, 32'h480, 1'b0, 0);
        @(negedge clk);
        chk("blt_taken", {31'd0, bus.bj_taken}, 32'd1);
        tick();
        ex(1'b0, 32'h410, BR, 3'd6, 32'hFFFF_FFFF, 1, 32'h490, 1'b0, 0);
        @(negedge clk);
        chk("bltu_taken", {31'd0, bus.bj_taken}, 32'd0);
        chk("bltu_redirect", bus.redirect_pc, 32'h414);
        tick();
        ex(1'b0, 32'h420, BR, 3'd7, 32'hFFFF_FFFF, 1, 32'h4A0, 1'b0, 0);
        @(negedge clk);
        chk("bgeu_taken", {31'd0, bus.bj_taken}, 32'd1);
        tick();

        // Counter saturation and hysteresis on BNE
        bus.if_pc = 32'h300;
        for (int k = 0; k < 3; k++) begin
            ex(1'b0, 32'h300, BR, 3'd1, 1, 2, 32'h380, k != 0, 32'h380);
            tick();
        end
        ex(1'b0, 32'h300, BR, 3'd1, 2, 2, 32'h380, 1'b1, 32'h380);
        @(negedge clk);
        chk("bne_cnt11", {31'd0, bus.pred_taken}, 32'd1);
        tick();
        @(negedge clk);
        chk("bne_cnt10", {31'd0, bus.pred_taken}, 32'd1);
        tick();
        idle();
        @(negedge clk);
        chk("bne_cnt01", {31'd0, bus.pred_taken}, 32'd0);
        chk("bne_cnt01_tgt", bus.pred_target, 32'h304);

        // JALR retarget, then a stalled retarget that must not write
        ex(1'b0, 32'h540, JALR, 3'd0, 0, 0, 32'h500, 1'b0, 0);
        tick();
        bus.if_pc = 32'h540;
        ex(1'b0, 32'h540, JALR, 3'd0, 0, 0, 32'h600, 1'b1, 32'h500);
        @(negedge clk);
        chk("jalr_mispred", {31'd0, bus.mispredict}, 32'd1);
        chk("jalr_old_tgt", bus.pred_target, 32'h500);
        tick();
        ex(1'b1, 32'h540, JALR, 3'd0, 0, 0, 32'h700, 1'b1, 32'h600);
        @(negedge clk);
        chk("jalr_new_tgt", bus.pred_target, 32'h600);
        tick();
        idle();
        @(negedge clk);
        chk("stall_no_write", bus.pred_target, 32'h600);
        tick();

        ex(1'b0, 32'h600, 7'b0110011, 3'd0, 1, 1, 32'h800, 1'b1, 32'h800);
        @(negedge clk);
        chk("alu_not_ctrl", {31'd0, bus.mispredict}, 32'd0);
        tick();

        // Alias at the JALR slot replaces it
        ex(1'b0, 32'h1540, JAL, 3'd0, 0, 0, 32'h1300, 1'b0, 0);
        tick();
        idle();
        @(negedge clk);
        chk("alias_evicted", {31'd0, bus.pred_taken}, 32'd0);
        #1 bus.if_pc = 32'h1540;
        #1 chk("alias_new_tgt", bus.pred_target, 32'h1300);
        bus.if_pc = 32'hFFFF_FFFC;
        #1 chk("pc_wrap", bus.pred_target, 32'h0);
        tick();

        // Perf counters: 4 transfers, 1 mispredict, plus ignored ones
        #2 rst_n = 1'b0;
        #2 rst_n = 1'b1;
        bus.if_pc = 32'h208;
        tick();
        ex(1'b0, 32'h200, BR, 3'd0, 7, 7, 32'h240, 1'b1, 32'h240);
        tick();
        ex(1'b0, 32'h204, BR, 3'd1, 7, 7, 32'h280, 1'b0, 0);
        tick();
        ex(1'b1, 32'h204, BR, 3'd0, 7, 7, 32'h280, 1'b0, 0);
        tick();
        ex(1'b0, 32'h208, JAL, 3'd0, 0, 0, 32'h300, 1'b1, 32'h300);
        tick();
        ex(1'b0, 32'h20C, JALR, 3'd0, 0, 0, 32'h400, 1'b0, 0);
        tick();
        idle();
        @(negedge clk);
`ifdef BRANCH_PERF_EN
        chk("perf_br4", perf_br_cnt, 32'd4);
        chk("perf_mis1", perf_mispred_cnt, 32'd1);
`else
        chk("perf_br_off", perf_br_cnt, 32'd0);
        chk("perf_mis_off", perf_mispred_cnt, 32'd0);
`endif
        chk("perf_pred_jal", bus.pred_target, 32'h300);
        tick();

        // Reset asserted mid-update clears table and counters
        ex(1'b0, 32'h208, JAL, 3'd0, 0, 0, 32'h900, 1'b1, 32'h300);
        #2 rst_n = 1'b0;
        @(negedge clk);
        chk("rst_mid_br", perf_br_cnt, 32'd0);
        chk("rst_mid_mis", perf_mispred_cnt, 32'd0);
        chk("rst_mid_valid", {31'd0, bus.pred_taken}, 32'd0);
        tick();
        idle();
        #2 rst_n = 1'b1;
        @(negedge clk);
        chk("rst_no_write", {31'd0, bus.pred_taken}, 32'd0);
        chk("rst_pred_tgt2", bus.pred_target, 32'h20C);
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/branch_predict_resolve.md
# branch_predict_resolve

Parametrised branch unit for the 5-stage RV32I core: an IF-stage direction/target predictor (direct-mapped BTB with 2-bit saturating counters) combined with EX-stage branch/jump resolution and misprediction detection. IF consumes `pred_taken`/`pred_target` to select the next PC. EX consumes `mispredict`/`redirect_pc` to flush IF/ID and redirect fetch. The table is trained every cycle a control-transfer instruction retires from EX.

## Interface
- `XLEN`, 32, datapath/PC width
- `BTB_DEPTH`, 64, entries; power of two, ≥4; `IDX_W = log2(BTB_DEPTH)`
- `TAG_W`, 8, tag bits; requires `IDX_W+TAG_W+2 ≤ XLEN`

- `clk` in 1: clock
- `rst_n` in 1: reset, asynchronous, active-low
- `if_pc` in XLEN: fetch PC
- `pred_taken` out 1: predicted taken
- `pred_target` out XLEN: predicted next PC
- `ex_valid` in 1: EX holds a valid instruction
- `ex_stall` in 1: EX frozen this cycle
- `ex_pc` in XLEN: PC of EX instruction
- `ex_opcode` in 7: opcode
- `ex_func3` in 3: funct3
- `ex_rs1`, `ex_rs2` in XLEN: forwarded operands
- `ex_target` in XLEN: ALU-computed target (pc+imm, or rs1+imm with bit0 cleared)
- `ex_pred_taken` in 1: prediction piped from IF
- `ex_pred_target` in XLEN: predicted target piped from IF
- `bj_taken` out 1: resolved outcome
- `mispredict` out 1: flush request
- `redirect_pc` out XLEN: correct next PC
- `perf_br_cnt` out 32: resolved control transfers
- `perf_mispred_cnt` out 32: mispredictions

## Operation
- Index is `pc[IDX_W+1:2]`. Tag is `pc[IDX_W+TAG_W+1:IDX_W+2]`.
- Each entry holds `valid`, `tag`, `target[XLEN-1:0]`, `jmp`, and `cnt[1:0]`.
- Lookup: `hit = valid & tag match`.
  - `pred_taken = hit & (jmp | cnt[1])`.
  - `pred_target = pred_taken ? target : if_pc+4`, with wrap modulo 2^XLEN.
- Control-transfer opcodes: B `1100011`, JAL `1101111`, JALR `1100111`. Any other opcode gives `bj_taken=0`, `mispredict=0`, and no update.
- Branch conditions by func3:
  - 000 eq
  - 001 ne
  - 100 signed lt
  - 101 signed ge
  - 110 unsigned lt
  - 111 unsigned ge
  - 010/011 not taken
- JAL and JALR are always taken.
- `redirect_pc = bj_taken ? ex_target : ex_pc+4`.
- `mispredict = ex_valid & ctrl & (ex_pred_taken != bj_taken | (bj_taken & ex_pred_target != ex_target))`.
- Update happens when `ex_valid & ~ex_stall & ctrl`, using a lookup on `ex_pc`:
  - Hit, branch: `cnt` saturating ±1 (taken up, not-taken down); 11 and 00 hold. `target` is rewritten if taken.
  - Hit, jump: `target` rewritten, `jmp=1`, `cnt=11`.
  - Miss and taken: allocate (overwrite). `valid=1`, tag/target written. Branch gets `cnt=10`, `jmp=0`. Jump gets `cnt=11`, `jmp=1`.
  - Miss and not taken: no write.
- Aliased tag (same index, different tag) counts as a miss and is replaced on a taken outcome.

## Timing
- Prediction and resolution outputs are combinational, with zero latency.
- Table writes occur at the `clk` rising edge. They are visible to lookups from the next cycle.
- If IF and EX address the same entry in the same cycle, IF sees the pre-update contents. There is no bypass.
- `ex_stall=1` blocks the update and the perf increments. The combinational outputs still reflect inputs; the pipeline ignores them.
- Asynchronous reset (`rst_n=0`) at any time, including mid-update:
  - All entries get `valid=0`, `cnt=01`, `jmp=0`, `tag=0`, `target=0`.
  - Perf counters clear to 0.
  - Outputs then read `pred_taken=0`, `pred_target=if_pc+4`, and `mispredict=0` unless EX inputs are driven.
  - Release is synchronised by the top level; this block samples no writes while `rst_n=0`.

## Configuration
- Macro: `BRANCH_PERF_EN`.
- Defined:
  - `perf_br_cnt` increments on every update-qualified control transfer.
  - `perf_mispred_cnt` increments when such an update also has `mispredict=1`.
  - Both are 32-bit and wrap from 0xFFFFFFFF to 0.
- Undefined: both ports are tied to 0 and no counter flops are generated. The port list is unchanged.

## Test plan
- Reset: `pred_taken=0`, and `pred_target=0x104` for `if_pc=0x100`.
- BEQ at 0x200, `rs1=rs2=5`, target 0x240, `ex_pred_taken=0`, resolved twice:
  - First: `bj_taken=1`, `mispredict=1`, `redirect_pc=0x240`, entry allocated `cnt=10`.
  - Next-cycle IF at 0x200 gives `pred_taken=1`, `pred_target=0x240`.
- Signed/unsigned compare, `rs1=0xFFFFFFFF`, `rs2=1`:
  - BLT → taken.
  - BLTU → not taken, `redirect_pc=pc+4`.
  - BGEU → taken.
- Counter saturation, repeated BNE at 0x300:
  - Three taken outcomes reach `cnt=11`.
  - Then one not-taken (`cnt=10`) still predicts taken.
  - A second not-taken drops to `cnt=01`, predicting not taken.
- JALR with target changing 0x500→0x600 and `ex_pred_target=0x500`: `mispredict=1`, entry target becomes 0x600. With `ex_stall=1`, the entry is unchanged.
- `BRANCH_PERF_EN`: after 4 control transfers with 1 misprediction, the counters read 4 and 1. Asserting `rst_n=0` mid-sequence clears both and all `valid` bits.
